ma_module: RTL

Memory-access pipeline stage. It sits directly downstream of the execute stage and consumes its EX/MA register outputs (pc, ALU result, rs2 data, instruction). It runs RV32I loads and stores over a single-outstanding request/ready data bus, aligns and extends load data, and drives a combinational trim_forward value back to the execute stage. It registers the MA/WB pipeline outputs.

---
 rtl/ma_pkg.sv | 62 ++++++
 rtl/ma_module_if.sv | 22 ++
 rtl/ma_module_load_align.sv | 33 +++
 rtl/pp_register.sv | 20 ++
 rtl/ma_module.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/ma_pkg.sv
// Shared decode constants, FSM encoding and bus payload type for the memory-access stage.
package ma_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_BUSY = 2'd1,
    MA_DONE = 2'd2
  } ma_state_e;

  // Request captured at issue so it stays stable while the slave inserts waits.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        load;
    logic [2:0]  funct3;
    logic [1:0]  lo;
  } dbus_req_t;

  // Store encodings with funct3[2] set are undefined and behave as word accesses.
  function automatic logic [1:0] access_size(input logic is_store, input logic [2:0] f3);
    logic [1:0] sz;
    sz = SZ_W;
    if (!(is_store && f3[2])) begin
      case (f3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic m;
    case (sz)
      SZ_H:    m = lo[0];
      SZ_W:    m = |lo;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ma_module_if.sv
// Single-outstanding request/ready data bus between the MA stage and the data memory.
interface ma_module_if;
  import ma_pkg::*;

  logic              dbus_req;
  logic              dbus_we;
  logic [DATA_W-1:0] dbus_addr;
  logic [3:0]        dbus_be;
  logic [DATA_W-1:0] dbus_wdata;
  logic              dbus_ready;
  logic [DATA_W-1:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ready, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ready, dbus_rdata
  );
endinterface

// File: rtl/ma_module_load_align.sv
// Selects the addressed byte/halfword lane of a load word and sign/zero extends it.
module ma_module_load_align
  import ma_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata[7:0];
    case (lo)
      2'd1:    byte_c = rdata[15:8];
      2'd2:    byte_c = rdata[23:16];
      2'd3:    byte_c = rdata[31:24];
      default: byte_c = rdata[7:0];
    endcase
    half_c = lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data_c = {{24{byte_c[7]}}, byte_c};
      F3_BU:   data_c = {24'd0, byte_c};
      F3_H:    data_c = {{16{half_c[15]}}, half_c};
      F3_HU:   data_c = {16'd0, half_c};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/pp_register.sv
// Pipeline register cell: clear to bubble value beats load; otherwise holds.
module pp_register #(
  parameter int unsigned   W    = 32,
  parameter logic [W-1:0]  INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       q <= INIT;
    else if (clear) q <= INIT;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/ma_module.sv
// RV32I memory-access stage: load/store over a request/ready bus, MA/WB registers.
// Build option MA_MISALIGN_TRAP_EN adds a registered misalign_exc output.
module ma_module
  import ma_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF,
  parameter int unsigned XLEN     = DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_ma,
  input  logic [XLEN-1:0] alu_ma,
  input  logic [XLEN-1:0] d2_ma,
  input  logic [XLEN-1:0] inst_ma,
  input  logic            hold,
  input  logic            flush,
  ma_module_if.master     dbus,
  output logic            stall_req,
  output logic [XLEN-1:0] trim_forward,
  output logic [XLEN-1:0] pc_wb,
  output logic [XLEN-1:0] alu_wb,
  output logic [XLEN-1:0] dout_wb,
  output logic [XLEN-1:0] inst_wb
`ifdef MA_MISALIGN_TRAP_EN
  ,
  output logic            misalign_exc
`endif
);

  ma_state_e   state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] buf_q, buf_d;
  dbus_req_t   held_q, req_now_c, act_c;

  logic        load_c, store_c, mem_c, mis_c, issue_c;
  logic [2:0]  f3_c;
  logic [1:0]  size_c;
  logic [31:0] ext_c, wb_dout_c;
  logic        req_c, stall_c, done_c, wb_bubble_c, wb_clear_c, wb_load_c;

  // Decode and build the request for the instruction currently in MA.
  always_comb begin
    load_c  = (inst_ma[6:0] == OPC_LOAD);
    store_c = (inst_ma[6:0] == OPC_STORE);
    mem_c   = load_c | store_c;
    f3_c    = inst_ma[14:12];
    size_c  = access_size(store_c, f3_c);

    req_now_c.we     = store_c;
    req_now_c.addr   = {alu_ma[31:2], 2'b00};
    req_now_c.load   = load_c;
    req_now_c.funct3 = f3_c;
    req_now_c.lo     = alu_ma[1:0];
    req_now_c.be     = 4'b1111;
    req_now_c.wdata  = d2_ma;
    if (store_c) begin
      case (size_c)
        SZ_B: begin
          req_now_c.be    = 4'(4'b0001 << alu_ma[1:0]);
          req_now_c.wdata = {4{d2_ma[7:0]}};
        end
        SZ_H: begin
          req_now_c.be    = alu_ma[1] ? 4'b1100 : 4'b0011;
          req_now_c.wdata = {2{d2_ma[15:0]}};
        end
        default: ;
      endcase
    end
  end

`ifdef MA_MISALIGN_TRAP_EN
  assign mis_c = mem_c & misaligned(size_c, alu_ma[1:0]);
`else
  assign mis_c = 1'b0;
`endif

  assign issue_c = mem_c & ~flush & ~mis_c;
  assign act_c   = (state_q == MA_BUSY) ? held_q : req_now_c;

  ma_module_load_align u_align (
    .rdata  (dbus.dbus_rdata),
    .lo     (act_c.lo),
    .funct3 (act_c.funct3),
    .data_c (ext_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MA_IDLE;
      discard_q <= 1'b0;
      buf_q     <= '0;
      held_q    <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      buf_q     <= buf_d;
      if (state_q == MA_IDLE && issue_c) held_q <= req_now_c;
    end
  end

  // Next state, bus request, stall and WB bubble control.
  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    buf_d       = buf_q;
    req_c       = 1'b0;
    stall_c     = 1'b0;
    done_c      = 1'b0;
    wb_bubble_c = 1'b0;
    case (state_q)
      MA_IDLE: begin
        if (issue_c) begin
          req_c = 1'b1;
          if (dbus.dbus_ready) begin
            done_c = 1'b1;
            if (hold) state_d = MA_DONE;
          end else begin
            state_d     = MA_BUSY;
            stall_c     = 1'b1;
            wb_bubble_c = 1'b1;
          end
        end
      end
      MA_BUSY: begin
        req_c = 1'b1;
        if (flush) discard_d = 1'b1;
        if (dbus.dbus_ready) begin
          done_c      = 1'b1;
          state_d     = hold ? MA_DONE : MA_IDLE;
          wb_bubble_c = discard_q;
        end else begin
          stall_c     = 1'b1;
          wb_bubble_c = 1'b1;
        end
      end
      MA_DONE: begin
        if (flush) discard_d = 1'b1;
        if (!hold) state_d = MA_IDLE;
        wb_bubble_c = discard_q;
      end
      default: state_d = MA_IDLE;
    endcase
    if (done_c) buf_d = act_c.load ? ext_c : 32'd0;
    if (state_d == MA_IDLE) discard_d = 1'b0;
  end

  assign dbus.dbus_req   = req_c & rst;
  assign dbus.dbus_we    = act_c.we;
  assign dbus.dbus_addr  = act_c.addr;
  assign dbus.dbus_be    = act_c.be;
  assign dbus.dbus_wdata = act_c.wdata;

  assign stall_req    = stall_c & rst;
  assign trim_forward = (done_c && act_c.load) ? ext_c : alu_ma;

  assign wb_dout_c  = (done_c && act_c.load) ? ext_c :
                      (state_q == MA_DONE)   ? buf_q : 32'd0;
  assign wb_clear_c = flush | (~hold & wb_bubble_c);
  assign wb_load_c  = ~hold;

  pp_register #(.W(XLEN), .INIT('0)) u_pc_wb (
    .clk(clk), .rst(rst), .clear(wb_clear_c), .load(wb_load_c), .d(pc_ma), .q(pc_wb));
  pp_register #(.W(XLEN), .INIT('0)) u_alu_wb (
    .clk(clk), .rst(rst), .clear(wb_clear_c), .load(wb_load_c), .d(alu_ma), .q(alu_wb));
  pp_register #(.W(XLEN), .INIT('0)) u_dout_wb (
    .clk(clk), .rst(rst), .clear(wb_clear_c), .load(wb_load_c), .d(wb_dout_c), .q(dout_wb));
  pp_register #(.W(XLEN), .INIT(NOP_INST)) u_inst_wb (
    .clk(clk), .rst(rst), .clear(wb_clear_c), .load(wb_load_c), .d(inst_ma), .q(inst_wb));

`ifdef MA_MISALIGN_TRAP_EN
  pp_register #(.W(1), .INIT(1'b0)) u_mis_wb (
    .clk(clk), .rst(rst), .clear(wb_clear_c), .load(wb_load_c), .d(mis_c), .q(misalign_exc));
`endif

endmodule
